reset_sequencer: RTL and testbench

- Parametrised successor to the single-output reset extender.
- Takes one synchronous active-high reset request plus a software restart pulse, then holds all downstream reset domains for EXTEND_CYCLES.
- Releases NUM_CH active-low channel resets one at a time, lowest index first, separated by STAGE_GAP cycles.
- Sits between the board/PLL reset source and the bridge sub-blocks so that dependent domains leave reset in a fixed order.

---
 rtl/reset_sequencer.sv | 63 ++++++
 tb/tb_reset_sequencer.sv | 113 +++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds NUM_CH active-low resets for EXTEND_CYCLES after a reset event,
// then releases them lowest index first, STAGE_GAP idle cycles apart.
module reset_sequencer #(
  parameter int NUM_CH = 4,
  parameter int EXTEND_CYCLES = 4,
  parameter int STAGE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              soft_rst_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              seq_done,
  output logic              seq_busy
);
  localparam int MAXV = EXTEND_CYCLES > STAGE_GAP ? EXTEND_CYCLES : STAGE_GAP;
  localparam int CW = MAXV < 1 ? 1 : $clog2(MAXV + 1);
  localparam int IW = $clog2(NUM_CH + 1);
  typedef enum logic [1:0] {HOLD = 2'd0, RELEASE = 2'd1, DONE = 2'd2} state_t;
  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [IW-1:0]     idx, idx_d;
  logic [NUM_CH-1:0] rel_d;
  logic              done_d;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    idx_d = idx;
    rel_d = rst_n_out;
    if (soft_rst_req || !(state == HOLD || state == RELEASE || state == DONE)) begin
      state_d = HOLD;
      cnt_d = CW'(EXTEND_CYCLES);
      idx_d = '0;
      rel_d = '0;
    end else if (state == DONE) begin
      rel_d = '1;
    end else if (cnt != '0) begin
      cnt_d = cnt - CW'(1);
    end else begin
      for (int k = 0; k < NUM_CH; k++) if (idx == IW'(k)) rel_d[k] = 1'b1;
      idx_d = idx + IW'(1);
      state_d = idx == IW'(NUM_CH - 1) ? DONE : RELEASE;
      cnt_d = CW'(STAGE_GAP);
    end
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= HOLD;
      cnt <= CW'(EXTEND_CYCLES);
      idx <= '0;
      rst_n_out <= '0;
      seq_done <= 1'b0;
      seq_busy <= 1'b1;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      rst_n_out <= rel_d;
      seq_done <= done_d;
      seq_busy <= !done_d;
    end
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: three parameterisations checked against an edges-since-reset-event model.
module tb_reset_sequencer;
  logic clk = 0;
  logic r0 = 1, s0 = 0, r1 = 1, s1 = 0, r2 = 1, s2 = 0;
  logic [3:0] o0;
  logic [0:0] o1;
  logic [2:0] o2;
  logic dn0, b0, dn1, b1, dn2, b2;
  int checks = 0, errors = 0;
  int e[3];
  bit v[3];
  always #5 clk = ~clk;
  reset_sequencer #(.NUM_CH(4), .EXTEND_CYCLES(4), .STAGE_GAP(2)) d0 (
    .clk(clk), .rst_in(r0), .soft_rst_req(s0), .rst_n_out(o0), .seq_done(dn0), .seq_busy(b0));
  reset_sequencer #(.NUM_CH(1), .EXTEND_CYCLES(0), .STAGE_GAP(0)) d1 (
    .clk(clk), .rst_in(r1), .soft_rst_req(s1), .rst_n_out(o1), .seq_done(dn1), .seq_busy(b1));
  reset_sequencer #(.NUM_CH(3), .EXTEND_CYCLES(4), .STAGE_GAP(0)) d2 (
    .clk(clk), .rst_in(r2), .soft_rst_req(s2), .rst_n_out(o2), .seq_done(dn2), .seq_busy(b2));
  function automatic logic [7:0] expv(int n, int ext, int gap, int ev);
    expv = '0;
    for (int k = 0; k < n; k++) expv[k] = ev >= ext + 1 + k * (gap + 1);
  endfunction
  task automatic cmp(string nm, int i, logic [7:0] a, logic d, logic b, int n, int ext, int gap);
    logic [7:0] x, m;
    logic xd;
    if (!v[i]) return;
    x = expv(n, ext, gap, e[i]);
    m = 8'((1 << n) - 1);
    xd = x == m;
    checks++;
    if ({a, d, b} !== {x, xd, !xd}) begin
      errors++;
      $display("FAIL %s edge+%0d: out=%b done=%b busy=%b, expected out=%b done=%b busy=%b",
               nm, e[i], a, d, b, x, xd, !xd);
    end
  endtask
  task automatic lit(string nm, logic [7:0] a, logic [7:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", nm, a, x);
    end
  endtask
  task automatic step();
    bit ev[3];
    ev[0] = r0 | s0;
    ev[1] = r1 | s1;
    ev[2] = r2 | s2;
    for (int i = 0; i < 3; i++) begin
      if (ev[i]) begin
        e[i] = 0;
        v[i] = 1;
      end else if (e[i] < 1000) e[i]++;
    end
    @(posedge clk);
    #1;
    cmp("d0", 0, 8'(o0), dn0, b0, 4, 4, 2);
    cmp("d1", 1, 8'(o1), dn1, b1, 1, 0, 0);
    cmp("d2", 2, 8'(o2), dn2, b2, 3, 4, 0);
  endtask
  initial begin
    repeat (3) step();
    lit("reset_out", 8'(o0), 0);
    lit("reset_busy", 8'(b0), 1);
    r0 = 0; r1 = 0; r2 = 0;
    for (int t = 1; t <= 30; t++) begin
      s0 = t == 9;
      s2 = t >= 10 && t <= 19;
      step();
      if (t == 1) begin lit("d1_ch0", 8'(o1), 1); lit("d1_done", 8'(dn1), 1); end
      if (t == 4) lit("d0_e4", 8'(o0), 4'b0000);
      if (t == 5) begin lit("d0_e5", 8'(o0), 4'b0001); lit("d2_e5", 8'(o2), 3'b001); end
      if (t == 7) begin lit("d2_e7", 8'(o2), 3'b111); lit("d2_done", 8'(dn2), 1); end
      if (t == 8) lit("d0_e8", 8'(o0), 4'b0011);
      if (t == 9) begin lit("d0_soft", 8'(o0), 4'b0000); lit("d0_soft_busy", 8'(b0), 1); end
      if (t == 14) lit("d0_e14", 8'(o0), 4'b0001);
      if (t == 17) lit("d0_e17", 8'(o0), 4'b0011);
      if (t == 19) lit("d2_held", 8'(o2), 3'b000);
      if (t == 23) begin
        lit("d0_e23", 8'(o0), 4'b1111);
        lit("d0_done", 8'(dn0), 1);
        lit("d2_e23", 8'(o2), 3'b000);
      end
      if (t == 24) lit("d2_e24", 8'(o2), 3'b001);
    end
    r0 = 1; step(); r0 = 0;
    for (int t = 1; t <= 11; t++) step();
    lit("d0_pre_rst", 8'(o0), 4'b0111);
    r0 = 1; step(); r0 = 0;
    lit("d0_mid_rst", 8'(o0), 0);
    lit("d0_mid_rst_done", 8'(dn0), 0);
    repeat (5) step();
    lit("d0_after_rst", 8'(o0), 4'b0001);
    r0 = 1; s0 = 1; step(); r0 = 0; s0 = 0;
    lit("d0_both", 8'(o0), 0);
    for (int t = 1; t <= 11; t++) begin
      s0 = t == 11;
      step();
    end
    s0 = 0;
    lit("d0_soft_on_rel", 8'(o0), 0);
    repeat (14) step();
    lit("d0_restart_done", 8'(dn0), 1);
    for (int t = 0; t < 3000; t++) begin
      r0 = $urandom_range(63) == 0; s0 = $urandom_range(24) == 0;
      r1 = $urandom_range(15) == 0; s1 = $urandom_range(7) == 0;
      r2 = $urandom_range(63) == 0; s2 = s2 ? $urandom_range(3) != 0 : $urandom_range(30) == 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
